// File: rtl/s_axis_video_receiver.sv
// AXI4-Stream video slave: rebuilds pixel strobes and x/y, checks framing.
// Optional S_AXIS_ERR_CNT_EN adds a saturating 16-bit error-cycle counter.
module s_axis_video_receiver #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 10,
  parameter int IMG_HEIGHT = 10
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tuser,
  input  logic                  s_axis_tlast,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_pixel,
  output logic                  o_pixel_valid,
  output logic                  o_start_of_frame,
  output logic                  o_end_of_line,
  output logic                  o_end_of_frame,
  output logic [11:0]           o_x,
  output logic [11:0]           o_y,
`ifdef S_AXIS_ERR_CNT_EN
  output logic [15:0]           o_err_count,
`endif
  output logic                  o_err_short_line,
  output logic                  o_err_long_line,
  output logic                  o_err_early_sof
);

  localparam int BW = DATA_WIDTH + 27;
  localparam logic [11:0] X_LAST = 12'(IMG_WIDTH - 1);
  localparam logic [11:0] Y_LAST = 12'(IMG_HEIGHT - 1);

  typedef enum logic [1:0] {
    WAIT_SOF,
    ACTIVE,
    DISCARD
  } state_t;

  state_t        state_q, state_d;
  logic [11:0]   x_q, x_d, y_q, y_d;
  logic [11:0]   bx, by;
  logic          done_q, done_d;
  logic          acc, keep;
  logic          at_end, b_eol, b_eof;
  logic          e_sof, e_short, e_long;
  logic [BW-1:0] beat, out_q, skid_q;
  logic          skid_full_q, skid_full_d;
  logic          stall;

  assign acc   = s_axis_tvalid && s_axis_tready;
  assign stall = o_pixel_valid && !i_ready;

  // A tuser beat always restarts the geometry at (0,0).
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    done_d  = done_q;
    keep    = 1'b0;
    e_sof   = 1'b0;
    e_short = 1'b0;
    e_long  = 1'b0;
    bx      = s_axis_tuser ? 12'd0 : x_q;
    by      = s_axis_tuser ? 12'd0 : y_q;
    at_end  = (bx == X_LAST);
    b_eol   = s_axis_tlast || at_end;
    b_eof   = b_eol && (by == Y_LAST);
    if (acc) begin
      if (s_axis_tuser) begin
        keep  = 1'b1;
        e_sof = (state_q != WAIT_SOF);
      end else if (state_q == ACTIVE) begin
        keep = 1'b1;
      end else if (state_q == DISCARD && s_axis_tlast) begin
        state_d = done_q ? WAIT_SOF : ACTIVE;
        x_d     = 12'd0;
      end
    end
    if (keep) begin
      e_short = s_axis_tlast && !at_end && !s_axis_tuser;
      e_long  = at_end && !s_axis_tlast;
      if (b_eol) begin
        x_d    = 12'd0;
        y_d    = b_eof ? 12'd0 : by + 12'd1;
        done_d = b_eof;
        if (e_long)
          state_d = DISCARD;
        else
          state_d = b_eof ? WAIT_SOF : ACTIVE;
      end else begin
        x_d     = bx + 12'd1;
        y_d     = by;
        state_d = ACTIVE;
      end
    end
  end

  assign beat = {s_axis_tdata, s_axis_tuser, b_eol, b_eof, bx, by};
  assign {o_pixel, o_start_of_frame, o_end_of_line,
          o_end_of_frame, o_x, o_y} = out_q;

  // tready is low whenever the skid holds a beat, so no accept collides with a drain.
  assign skid_full_d = stall ? (skid_full_q || keep) : 1'b0;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q          <= WAIT_SOF;
      x_q              <= 12'd0;
      y_q              <= 12'd0;
      done_q           <= 1'b0;
      out_q            <= '0;
      skid_q           <= '0;
      o_pixel_valid    <= 1'b0;
      skid_full_q      <= 1'b0;
      s_axis_tready    <= 1'b0;
      o_err_short_line <= 1'b0;
      o_err_long_line  <= 1'b0;
      o_err_early_sof  <= 1'b0;
    end else begin
      state_q          <= state_d;
      x_q              <= x_d;
      y_q              <= y_d;
      done_q           <= done_d;
      skid_full_q      <= skid_full_d;
      s_axis_tready    <= !skid_full_d;
      o_err_short_line <= e_short && !e_sof;
      o_err_long_line  <= e_long;
      o_err_early_sof  <= e_sof;
      if (!stall) begin
        if (skid_full_q) begin
          out_q         <= skid_q;
          o_pixel_valid <= 1'b1;
        end else begin
          o_pixel_valid <= keep;
          if (keep)
            out_q <= beat;
        end
      end else if (keep) begin
        skid_q <= beat;
      end
    end
  end

`ifdef S_AXIS_ERR_CNT_EN
  logic any_err;
  assign any_err = o_err_short_line || o_err_long_line || o_err_early_sof;

  always_ff @(posedge i_clk) begin
    if (i_reset)
      o_err_count <= 16'd0;
    else if (any_err && o_err_count != 16'hFFFF)
      o_err_count <= o_err_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_s_axis_video_receiver.sv
// Bench for s_axis_video_receiver: directed and random beats vs a frame model.
// Geometry 4x3; o_err_count checked when S_AXIS_ERR_CNT_EN is defined.
module tb_s_axis_video_receiver;
  localparam int DW = 8;
  localparam int W  = 4;
  localparam int H  = 3;

  logic          i_clk;
  logic          i_reset;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          s_axis_tuser;
  logic          s_axis_tlast;
  logic          i_ready;
  logic [DW-1:0] o_pixel;
  logic          o_pixel_valid;
  logic          o_start_of_frame;
  logic          o_end_of_line;
  logic          o_end_of_frame;
  logic [11:0]   o_x;
  logic [11:0]   o_y;
  logic          o_err_short_line;
  logic          o_err_long_line;
  logic          o_err_early_sof;
`ifdef S_AXIS_ERR_CNT_EN
  logic [15:0]   o_err_count;
`endif

  s_axis_video_receiver #(
    .DATA_WIDTH(DW),
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H)
  ) dut (
    .i_clk           (i_clk),
    .i_reset         (i_reset),
    .s_axis_tdata    (s_axis_tdata),
    .s_axis_tvalid   (s_axis_tvalid),
    .s_axis_tready   (s_axis_tready),
    .s_axis_tuser    (s_axis_tuser),
    .s_axis_tlast    (s_axis_tlast),
    .i_ready         (i_ready),
    .o_pixel         (o_pixel),
    .o_pixel_valid   (o_pixel_valid),
    .o_start_of_frame(o_start_of_frame),
    .o_end_of_line   (o_end_of_line),
    .o_end_of_frame  (o_end_of_frame),
    .o_x             (o_x),
    .o_y             (o_y),
`ifdef S_AXIS_ERR_CNT_EN
    .o_err_count     (o_err_count),
`endif
    .o_err_short_line(o_err_short_line),
    .o_err_long_line (o_err_long_line),
    .o_err_early_sof (o_err_early_sof)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [34:0] exp_q[$];
  int          acc_q[$];

  bit m_in, m_skip;
  int m_col, m_row;

  logic [2:0]  pend = 3'b000;
  int          exp_errcnt = 0;
  int          n_out = 0, n_sof = 0, n_short = 0, n_long = 0;
  int          n_trdy_low = 0;
  bit          lat_chk = 1'b1;
  bit          gaps = 1'b0;
  int          bp_mode = 0;
  int          rk = 0;
  logic [35:0] prev_o = '0;
  bit          prev_stall = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
    end
  endtask

  // Frame model: tracks position inside the frame as plain integers.
  task automatic model_step(input bit u, input bit l,
                            input logic [7:0] d, output logic [2:0] e);
    bit eol, eof;
    e = 3'b000;
    if (u) begin
      e[2]   = m_in || m_skip;
      m_col  = 0;
      m_row  = 0;
      m_in   = 1'b1;
      m_skip = 1'b0;
    end else if (m_skip) begin
      if (l) m_skip = 1'b0;
      return;
    end else if (!m_in) begin
      return;
    end
    eol  = l || (m_col == W - 1);
    eof  = eol && (m_row == H - 1);
    e[1] = l && (m_col < W - 1) && !u;
    e[0] = (m_col == W - 1) && !l;
    exp_q.push_back({d, u, eol, eof, 12'(m_col), 12'(m_row)});
    acc_q.push_back(cyc);
    if (eol) begin
      if (e[0]) m_skip = 1'b1;
      m_col = 0;
      if (eof) begin
        m_row = 0;
        m_in  = 1'b0;
      end else begin
        m_row++;
      end
    end else begin
      m_col++;
    end
  endtask

  always @(posedge i_clk) begin
    #1;
    rk++;
    if (bp_mode == 0) i_ready = 1'b1;
    else if (bp_mode == 1) i_ready = (rk % 4 == 0) || (rk % 4 == 3);
    else i_ready = ($urandom_range(0, 2) != 0);
  end

  always @(negedge i_clk) begin
    logic [2:0]  e;
    logic [35:0] cur;
    logic [34:0] ex;
    int          a;
    cyc++;
    cur = {o_pixel_valid, o_pixel, o_start_of_frame, o_end_of_line,
           o_end_of_frame, o_x, o_y};
    if (o_err_early_sof) n_sof++;
    if (o_err_short_line) n_short++;
    if (o_err_long_line) n_long++;
    chk("err_pulses", {o_err_early_sof, o_err_short_line,
                       o_err_long_line}, pend);
`ifdef S_AXIS_ERR_CNT_EN
    chk("err_count", o_err_count, 16'(exp_errcnt));
`endif
    if (|pend) exp_errcnt++;
    if (prev_stall) chk("stall_stable", cur, prev_o);
    if (i_reset) begin
      exp_q.delete();
      acc_q.delete();
      m_in = 0; m_skip = 0; m_col = 0; m_row = 0;
      pend = 3'b000;
      exp_errcnt = 0;
      prev_stall = 1'b0;
    end else begin
      if (!s_axis_tready) n_trdy_low++;
      if (o_pixel_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_pixel", cur, 36'd0);
        end else begin
          ex = exp_q.pop_front();
          a  = acc_q.pop_front();
          chk("pixel", cur[34:0], ex);
          if (lat_chk) chk("latency", 64'(cyc - a), 64'd1);
          n_out++;
        end
      end
      prev_stall = o_pixel_valid && !i_ready;
      prev_o     = cur;
      pend       = 3'b000;
      if (s_axis_tvalid && s_axis_tready) begin
        model_step(s_axis_tuser, s_axis_tlast, s_axis_tdata, e);
        pend = e;
      end
    end
  end

  task automatic sync();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send(input bit u, input bit l);
    int n = 0;
    s_axis_tdata  = 8'($urandom);
    s_axis_tuser  = u;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    @(negedge i_clk);
    while (!s_axis_tready && n < 100) begin
      n++;
      @(negedge i_clk);
    end
    if (n >= 100) chk("send_timeout", 64'(n), 64'd0);
    sync();
    s_axis_tvalid = 1'b0;
    s_axis_tuser  = 1'b0;
    s_axis_tlast  = 1'b0;
    if (gaps && $urandom_range(0, 2) == 0) sync();
  endtask

  task automatic send_frame();
    for (int i = 0; i < W * H; i++) send(i == 0, (i % W) == W - 1);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      n++;
      sync();
    end
    repeat (3) sync();
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, {s_axis_tready, o_pixel_valid, o_pixel, o_start_of_frame,
              o_end_of_line, o_end_of_frame, o_x, o_y, o_err_short_line,
              o_err_long_line, o_err_early_sof}, 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int base, b2;
    i_reset       = 1'b1;
    i_ready       = 1'b1;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tuser  = 1'b0;
    s_axis_tlast  = 1'b0;

    sync();
    @(negedge i_clk);
    chk_zero("reset_outputs");
    sync();
    i_reset = 1'b0;
    @(negedge i_clk);
    chk("tready_at_release", s_axis_tready, 1'b0);
    @(negedge i_clk);
    chk("tready_after_release", s_axis_tready, 1'b1);
    sync();

    base = n_out;
    send_frame();
    drain();
    chk("clean_count", 64'(n_out - base), 64'd12);

    base = n_out;
    for (int i = 0; i < 5; i++) send(1'b0, i == 3);
    send_frame();
    drain();
    chk("garbage_count", 64'(n_out - base), 64'd12);

    base = n_out;
    b2   = n_short;
    send(1'b1, 1'b0);
    send(1'b0, 1'b0);
    send(1'b0, 1'b1);
    for (int i = 0; i < 8; i++) send(1'b0, (i % 4) == 3);
    drain();
    chk("short_pulses", 64'(n_short - b2), 64'd1);
    chk("short_count", 64'(n_out - base), 64'd11);

    base = n_out;
    b2   = n_long;
    for (int i = 0; i < 4; i++) send(i == 0, i == 3);
    for (int i = 0; i < 6; i++) send(1'b0, i == 5);
    for (int i = 0; i < 4; i++) send(1'b0, i == 3);
    drain();
    chk("long_pulses", 64'(n_long - b2), 64'd1);
    chk("long_count", 64'(n_out - base), 64'd12);

    bp_mode = 1;
    lat_chk = 1'b0;
    base    = n_out;
    b2      = n_trdy_low;
    send_frame();
    drain();
    chk("bp_count", 64'(n_out - base), 64'd12);
    chk("bp_tready_dropped", 64'(n_trdy_low - b2 > 0), 64'd1);
    bp_mode = 0;
    repeat (2) sync();
    lat_chk = 1'b1;

    for (int i = 0; i < 5; i++) send(i == 0, i == 3);
    i_reset = 1'b1;
    @(negedge i_clk);
    @(negedge i_clk);
    chk_zero("midframe_reset");
    sync();
    i_reset = 1'b0;
    @(negedge i_clk);
    chk("tready_release2", s_axis_tready, 1'b0);
    @(negedge i_clk);
    chk("tready_return2", s_axis_tready, 1'b1);
    sync();
    base = n_out;
    for (int i = 0; i < 3; i++) send(1'b0, 1'b0);
    send_frame();
    drain();
    chk("post_reset_count", 64'(n_out - base), 64'd12);

    base = n_out;
    b2   = n_sof;
    for (int i = 0; i < 6; i++) send(i == 0, (i % 4) == 3);
    send_frame();
    drain();
    chk("early_sof_pulses", 64'(n_sof - b2), 64'd1);
    chk("early_sof_count", 64'(n_out - base), 64'd18);
`ifdef S_AXIS_ERR_CNT_EN
    chk("err_count_sof", o_err_count, 16'd1);
`endif

    bp_mode = 2;
    lat_chk = 1'b0;
    gaps    = 1'b1;
    base    = n_out;
    send(1'b1, 1'b0);
    for (int i = 0; i < 150; i++)
      send($urandom_range(0, 15) == 0, $urandom_range(0, 4) == 0);
    drain();
    chk("random_some_out", 64'(n_out > base), 64'd1);
    bp_mode = 0;
    repeat (2) sync();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/s_axis_video_receiver.md
Name: s_axis_video_receiver

Overview:
- AXI4-Stream video slave; receiving end of the gradient pipeline's M_AXIS video link.
- Accepts beats framed by tuser (start of frame) and tlast (end of line).
- Rebuilds pixel/valid/start-of-frame strobes plus x/y coordinates for the downstream kernel/line-buffer logic.
- Checks framing against the IMG_WIDTH x IMG_HEIGHT geometry, flags violations and resynchronises.

Parameters:
- DATA_WIDTH, 8, pixel width in bits
- IMG_WIDTH, 10, pixels per line
- IMG_HEIGHT, 10, lines per frame

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- s_axis_tdata  in  DATA_WIDTH  pixel data
- s_axis_tvalid  in  1  beat valid
- s_axis_tready  out  1  beat accept; registered
- s_axis_tuser  in  1  start of frame, on the first pixel
- s_axis_tlast  in  1  end of line, on the last pixel of each line
- i_ready  in  1  downstream can take an output pixel
- o_pixel  out  DATA_WIDTH  received pixel
- o_pixel_valid  out  1  o_pixel and its qualifiers are valid
- o_start_of_frame  out  1  pixel is (0,0)
- o_end_of_line  out  1  pixel is the last of its line
- o_end_of_frame  out  1  pixel is the last of the frame
- o_x  out  12  column of the pixel
- o_y  out  12  line of the pixel
- o_err_short_line  out  1  pulse: tlast arrived before column IMG_WIDTH-1
- o_err_long_line  out  1  pulse: no tlast at column IMG_WIDTH-1
- o_err_early_sof  out  1  pulse: tuser arrived mid-frame

Behaviour:
- Clock and reset: one clock, i_clk; reset i_reset is synchronous and active-high.
- Reset values: all outputs 0, including s_axis_tready. Internal counters are cleared and the FSM goes to WAIT_SOF. A reset asserted mid-frame abandons the frame; no partial flags are emitted.
- Beat acceptance: a beat is accepted when s_axis_tvalid && s_axis_tready.
- Output stage: an output register plus a one-entry skid register.
  - s_axis_tready <= !skid_full, registered. It first rises the cycle after reset deasserts.
  - Accepted kept beats appear on o_* the cycle after acceptance when not stalled: latency 1.
  - While o_pixel_valid && !i_ready, all o_* hold stable. A beat accepted in that cycle goes to the skid; the skid drains into the output register first when i_ready returns.
  - No beat is lost or duplicated.
- Discarded beats are accepted (tready unaffected) but never reach the output stage.
- Counters: x and y are 12 bits. Coordinates are those of the pixel being emitted.
- FSM states:
  - WAIT_SOF:
    - Accepted beats without tuser are discarded.
    - An accepted beat with tuser is kept with x=0, y=0, o_start_of_frame=1; go to ACTIVE.
  - ACTIVE, per accepted beat:
    - tuser=1: o_err_early_sof pulses. The beat restarts the frame: kept as (0,0) with start_of_frame. Stay in ACTIVE.
    - tlast=1 && x<IMG_WIDTH-1: o_err_short_line pulses. Beat kept with o_end_of_line=1; x<=0, y<=y+1.
    - x==IMG_WIDTH-1 && tlast=1: normal end of line. Beat kept with o_end_of_line=1; x<=0, y<=y+1.
    - x==IMG_WIDTH-1 && tlast=0: o_err_long_line pulses. Beat kept with o_end_of_line=1; y<=y+1; go to DISCARD.
    - Any end of line with y==IMG_HEIGHT-1: also o_end_of_frame=1; y<=0; go to WAIT_SOF (or to DISCARD on a long line, which then returns to WAIT_SOF).
    - Otherwise: beat kept; x<=x+1.
  - DISCARD:
    - Accepted beats are discarded until a tlast beat is accepted (also discarded).
    - Then go to ACTIVE with x=0, or to WAIT_SOF if the frame had ended.
    - A tuser beat seen in DISCARD is kept as a new (0,0) frame and raises o_err_early_sof.
- Error pulses:
  - Each is a single cycle, registered the cycle after the offending acceptance.
  - Not gated by i_ready.
  - Priority when tuser and tlast arrive on the same beat: early_sof over short_line.

Optional Feature:
- Macro: S_AXIS_ERR_CNT_EN.
- Defined: adds output o_err_count, 16 bits.
  - Increments by 1 for each cycle in which any error pulse is high.
  - Saturates at 16'hFFFF; cleared only by i_reset.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan (IMG_WIDTH=4, IMG_HEIGHT=3 unless noted):
- Clean frame, i_ready=1, tvalid=1: 12 beats with tuser on beat 0 and tlast on beats 3/7/11 -> o_pixel_valid for 12 consecutive cycles, each 1 cycle after acceptance.
  - o_x sequence 0..3 repeated; o_y 0,0,0,0,1,...,2.
  - eol on beats 3/7/11; eof on beat 11; no error pulses.
- Garbage before SOF: 5 beats without tuser, then a clean frame -> the 5 beats are discarded, then 12 outputs exactly as in the clean-frame case.
- Short line: tlast on beat 2 of line 0 -> o_err_short_line pulses once.
  - That pixel is (2,0) with eol; the next pixel is (0,1).
- Long line: line 1 has 6 beats with tlast on the 6th -> o_err_long_line pulses once.
  - Pixel (3,1) carries eol; beats 5-6 are discarded; the next pixel is (0,2).
- Backpressure: i_ready toggles 1,0,0,1 repeatedly over a clean frame -> o_* stable while stalled.
  - s_axis_tready drops while the skid is full; all 12 pixels delivered in order; none dropped or duplicated.
- Mid-frame tuser and reset:
  - tuser at beat 6 -> o_err_early_sof pulses and that pixel is (0,0) with sof.
  - Separately, i_reset at beat 5 -> all outputs 0 next cycle; tready returns 1 cycle after release; beats wait for a new tuser.
  - With S_AXIS_ERR_CNT_EN defined: o_err_count==1 after the tuser case.
